mul_wb_buffer: RTL and testbench
================================

Name: mul_wb_buffer

Overview:
- Sits directly downstream of the last multiplier-pipeline register (M-stage output).
- Captures completed multiply results (type, pc, result, ROB id) into a small in-order FIFO.
- Presents them to the ROB writeback port with a valid/ready handshake.
- Asserts a stall back into the M pipeline when full, so the upstream registers hold.

Parameters:
- WORD_SIZE, `WORD_SIZE, width of pc and result
- INSTR_TYPE_SZ, `INSTR_TYPE_SZ, width of instruction type field
- ROB_ENTRY_WIDTH, `ROB_ENTRY_WIDTH, width of ROB id
- DEPTH, 4, FIFO entries; power of two, ≥2

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  reset, synchronous, active-high
- flush  input  1  synchronous drop of all buffered entries (misprediction/exception)
- in_valid  input  1  M-stage output holds a completed multiply
- in_instruction_type  input  INSTR_TYPE_SZ  type of incoming instruction
- in_pc  input  WORD_SIZE  pc of incoming instruction
- in_result  input  WORD_SIZE  multiply result
- in_rob_id  input  ROB_ENTRY_WIDTH  ROB entry of incoming instruction
- stall_out  output  1  upstream must hold; combinational, equals full
- wb_valid  output  1  head entry available
- wb_ready  input  1  ROB accepts head this cycle
- wb_instruction_type  output  INSTR_TYPE_SZ  head type
- wb_pc  output  WORD_SIZE  head pc
- wb_result  output  WORD_SIZE  head result
- wb_rob_id  output  ROB_ENTRY_WIDTH  head ROB id
- count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: DEPTH-entry circular array with head and tail pointers of width $clog2(DEPTH), wrapping modulo DEPTH, plus occupancy count.
- full = (count == DEPTH); empty = (count == 0).
- stall_out = full. It is purely count-based: no accept-on-full even if a dequeue occurs the same cycle.
- enq = in_valid && !full; on enq, write entry at tail and advance tail.
- deq = wb_valid && wb_ready; on deq, advance head.
- count next = count + enq - deq. Simultaneous enq and deq leaves count unchanged.
- wb_valid = !empty. wb_* outputs read the head entry combinationally; when empty, all wb_* data outputs are forced to 0.
- Latency: an entry enqueued at edge N is visible on wb_* after edge N. There is no same-cycle input-to-output bypass, even when empty.
- Ordering: strict FIFO; ROB ids leave in arrival order.
- wb_ready while empty: no effect.
- in_valid while full: not accepted. Upstream is stalled and re-presents the same entry, so no loss.
- reset (highest priority): head = tail = count = 0, wb_valid = 0, wb_* = 0, stall_out = 0. Storage contents don't care but are never visible. In-flight in_valid in that cycle is dropped.
- flush (second priority): same pointer/count clear as reset. in_valid and deq in the flush cycle are ignored. Reset mid-operation and flush both take effect at the next edge; outputs are empty the following cycle.
- No X on outputs after reset. Storage write is gated by enq only.

Test Plan:
- Reset with in_valid=1, in_rob_id=3 -> after edge count=0, wb_valid=0, wb_result=0, stall_out=0.
- Single entry: in_valid=1, pc=0x100, result=0x2A, rob_id=5, wb_ready=0 -> next cycle wb_valid=1, wb_result=0x2A, wb_rob_id=5, count=1; then wb_ready=1 for one cycle -> wb_valid=0, count=0.
- Fill: 4 back-to-back entries rob_id 1..4, wb_ready=0 -> count=4, stall_out=1. A 5th in_valid (rob_id 5) held for 2 cycles is not written. Raise wb_ready for one cycle -> rob_id 1 leaves, stall_out=0; next edge accepts rob_id 5. Drain order is 2,3,4,5.
- Steady stream: in_valid=1 and wb_ready=1 every cycle for 10 cycles with rob_id 0..9 -> count stays 1 after the first edge; wb_rob_id sequence is 0..9 one cycle delayed; pointers wrap twice without error.
- Simultaneous at full-1: count=3, in_valid=1, wb_ready=1 -> count stays 3, head advances, new entry at tail.
- Flush with count=3 and in_valid=1 -> next cycle count=0, wb_valid=0, wb_*=0; the following in_valid entry is the next wb output.

Source files
------------

// File: rtl/mul_wb_buffer.sv
// mul_wb_buffer: in-order FIFO between the multiplier M stage and ROB writeback.
// Stalls the M stage while full; the head entry is presented combinationally.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 5
`endif

module mul_wb_buffer #(
  parameter int WORD_SIZE       = `WORD_SIZE,
  parameter int INSTR_TYPE_SZ   = `INSTR_TYPE_SZ,
  parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH,
  parameter int DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [INSTR_TYPE_SZ-1:0]   in_instruction_type,
  input  logic [WORD_SIZE-1:0]       in_pc,
  input  logic [WORD_SIZE-1:0]       in_result,
  input  logic [ROB_ENTRY_WIDTH-1:0] in_rob_id,
  output logic                       stall_out,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [INSTR_TYPE_SZ-1:0]   wb_instruction_type,
  output logic [WORD_SIZE-1:0]       wb_pc,
  output logic [WORD_SIZE-1:0]       wb_result,
  output logic [ROB_ENTRY_WIDTH-1:0] wb_rob_id,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [INSTR_TYPE_SZ-1:0]   ty;
    logic [WORD_SIZE-1:0]       pc;
    logic [WORD_SIZE-1:0]       res;
    logic [ROB_ENTRY_WIDTH-1:0] rob;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic   w_full;
  logic   w_empty;
  logic   w_enq;
  logic   w_deq;
  entry_t w_in;
  entry_t w_head;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_enq   = in_valid && !w_full;
  assign w_deq   = !w_empty && wb_ready;

  assign w_in = '{ty:  in_instruction_type,
                  pc:  in_pc,
                  res: in_result,
                  rob: in_rob_id};

  // Storage is never reset; empty masking keeps stale data invisible.
  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_tail] <= w_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + 1'b1;
      if (w_deq) r_head <= r_head + 1'b1;
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
    end
  end

  assign w_head = w_empty ? '0 : r_mem[r_head];

  assign stall_out           = w_full;
  assign wb_valid            = !w_empty;
  assign wb_instruction_type = w_head.ty;
  assign wb_pc               = w_head.pc;
  assign wb_result           = w_head.res;
  assign wb_rob_id           = w_head.rob;
  assign count               = r_count;

endmodule

// File: tb/tb_mul_wb_buffer.sv
// tb_mul_wb_buffer: scoreboard bench for mul_wb_buffer.
// Stimulus pushes accepted entries; a negedge monitor pops on each handshake.
module tb_mul_wb_buffer;

  localparam int WS    = 32;
  localparam int TS    = 4;
  localparam int RW    = 5;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [TS-1:0] in_instruction_type = '0;
  logic [WS-1:0] in_pc = '0;
  logic [WS-1:0] in_result = '0;
  logic [RW-1:0] in_rob_id = '0;
  logic          stall_out;
  logic          wb_valid;
  logic          wb_ready = 1'b0;
  logic [TS-1:0] wb_instruction_type;
  logic [WS-1:0] wb_pc;
  logic [WS-1:0] wb_result;
  logic [RW-1:0] wb_rob_id;
  logic [CW-1:0] count;

  mul_wb_buffer #(
    .WORD_SIZE(WS), .INSTR_TYPE_SZ(TS),
    .ROB_ENTRY_WIDTH(RW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid),
    .in_instruction_type(in_instruction_type),
    .in_pc(in_pc), .in_result(in_result),
    .in_rob_id(in_rob_id),
    .stall_out(stall_out), .wb_valid(wb_valid),
    .wb_ready(wb_ready),
    .wb_instruction_type(wb_instruction_type),
    .wb_pc(wb_pc), .wb_result(wb_result),
    .wb_rob_id(wb_rob_id), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TS-1:0] ty;
    logic [WS-1:0] pc;
    logic [WS-1:0] res;
    logic [RW-1:0] id;
  } ent_t;

  ent_t exp_q[$];
  int   m_cnt = 0;
  int   m_next = 0;
  bit   mon_en = 0;
  bit   rst_seen = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // One clock cycle: reference occupancy advances, then new inputs go out.
  task automatic step(bit v, logic [TS-1:0] ty, logic [WS-1:0] pc,
                      logic [WS-1:0] res, logic [RW-1:0] id,
                      bit rdy, bit fl, bit rst, output bit acc);
    @(posedge clk);
    #1;
    m_cnt = m_next;
    if (rst_seen) mon_en = 1;
    in_valid = v; in_instruction_type = ty;
    in_pc = pc; in_result = res; in_rob_id = id;
    wb_ready = rdy; flush = fl; reset = rst;
    acc = 0;
    if (rst || fl) begin
      m_next = 0;
      exp_q.delete();
      if (rst) rst_seen = 1;
    end else begin
      acc = v && (m_cnt < DEPTH);
      m_next = m_cnt + int'(acc) - int'(rdy && m_cnt > 0);
      if (acc) exp_q.push_back('{ty, pc, res, id});
    end
  endtask

  task automatic idle(bit rdy);
    bit a;
    step(0, '0, '0, '0, '0, rdy, 0, 0, a);
  endtask

  // Monitor: samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 64'(count), 64'(m_cnt));
      chk("wb_valid", 64'(wb_valid), 64'(m_cnt != 0));
      chk("stall_out", 64'(stall_out), 64'(m_cnt == DEPTH));
      if (!wb_valid) begin
        chk("empty_data_zero",
            64'({wb_instruction_type, wb_rob_id, wb_pc != '0, wb_result != '0}),
            64'(0));
      end else if (wb_ready && !flush && !reset) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'(wb_rob_id), 64'hDEAD);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("wb_rob_id", 64'(wb_rob_id), 64'(e.id));
          chk("wb_result", 64'(wb_result), 64'(e.res));
          chk("wb_pc", 64'(wb_pc), 64'(e.pc));
          chk("wb_type", 64'(wb_instruction_type), 64'(e.ty));
        end
      end
    end
  end

  initial begin
    bit   a;
    ent_t p;
    bit   have;
    // Reset while an entry is offered: it must be dropped.
    step(1, 4'h1, 32'h0, 32'h0, 5'd3, 0, 0, 1, a);
    step(1, 4'h1, 32'h0, 32'h0, 5'd3, 0, 0, 1, a);
    idle(0);
    idle(0);
    // Single entry, held, then dequeued.
    step(1, 4'h2, 32'h100, 32'h2A, 5'd5, 0, 0, 0, a);
    idle(0);
    idle(1);
    idle(0);
    // Fill, then a 5th entry waits while full.
    for (int i = 1; i <= 4; i++)
      step(1, 4'h3, 32'h200 + i, 32'h1000 + i, RW'(i), 0, 0, 0, a);
    step(1, 4'h3, 32'h205, 32'h1005, 5'd5, 0, 0, 0, a);
    step(1, 4'h3, 32'h205, 32'h1005, 5'd5, 0, 0, 0, a);
    step(1, 4'h3, 32'h205, 32'h1005, 5'd5, 1, 0, 0, a);
    step(1, 4'h3, 32'h205, 32'h1005, 5'd5, 0, 0, 0, a);
    for (int i = 0; i < 5; i++) idle(1);
    // Steady stream through the buffer; pointers wrap.
    for (int i = 0; i < 10; i++)
      step(1, 4'h4, 32'h300 + i, 32'h2000 + i, RW'(i), 1, 0, 0, a);
    idle(1);
    idle(1);
    // Simultaneous enq/deq at count 3.
    for (int i = 0; i < 3; i++)
      step(1, 4'h5, 32'h400 + i, 32'h3000 + i, RW'(10 + i), 0, 0, 0, a);
    step(1, 4'h5, 32'h403, 32'h3003, 5'd13, 1, 0, 0, a);
    idle(0);
    // Flush with count 3 and in_valid high, then a fresh entry.
    step(1, 4'h6, 32'h500, 32'h4000, 5'd20, 1, 1, 0, a);
    step(1, 4'h7, 32'h600, 32'h5000, 5'd21, 0, 0, 0, a);
    idle(0);
    idle(1);
    idle(0);
    // Randomized traffic; a stalled entry is re-presented unchanged.
    have = 0;
    for (int i = 0; i < 600; i++) begin
      bit v, r, fl, rs;
      if (!have) begin
        p.ty  = TS'($urandom);
        p.pc  = $urandom;
        p.res = $urandom;
        p.id  = RW'($urandom);
      end
      v  = have || ($urandom_range(0, 99) < 60);
      r  = $urandom_range(0, 99) < 45;
      fl = $urandom_range(0, 99) < 3;
      rs = $urandom_range(0, 199) < 2;
      step(v, p.ty, p.pc, p.res, p.id, r, fl, rs, a);
      have = v && !a && !fl && !rs;
    end
    // Drain and confirm the scoreboard empties.
    for (int i = 0; i < DEPTH + 2; i++) idle(1);
    idle(0);
    @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
